calc_entry_sequencer: RTL and testbench
=======================================

# calc_entry_sequencer

Upstream input stage of the TinyTapeout calculator: turns raw switch and push-button activity on `ui_in` into one complete command (two 8-bit operands plus an opcode). It synchronises and debounces the buttons and assembles operands nibble by nibble. It then presents the finished command to the calculator core over a valid/ready handshake. All operator-facing timing lives here, so the core only ever sees clean, whole commands.

## Interface
- `DEBOUNCE_CYCLES`, default 1000: consecutive stable synchronised cycles before a button level is accepted (must be ≥ 2).
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ena`  in  1  design enable; when low, presses are ignored.
- `ui_in`  in  8  raw, asynchronous inputs:
  - [3:0] data nibble.
  - [5:4] opcode.
  - [6] clear button.
  - [7] enter button.
- `cmd_valid`  out  1  command available.
- `cmd_ready`  in  1  core accepts the command.
- `op_a`  out  8  operand A.
- `op_b`  out  8  operand B.
- `opcode`  out  2  operation selector.
- `stage`  out  3  current FSM state encoding, for status LEDs.

## Operation
- All 8 `ui_in` bits pass through a 2-flop synchroniser; nothing else samples raw `ui_in`.
- Enter and clear are debounced independently:
  - A counter runs while the synchronised level differs from the debounced level.
  - The counter clears whenever the two levels match.
  - The debounced level flips when the counter reaches `DEBOUNCE_CYCLES`.
- A press is a 1-cycle pulse on the debounced rising edge. Presses are gated by `ena`.
- FSM states and encodings: A_LO=0, A_HI=1, B_LO=2, B_HI=3, OP=4, ISSUE=5. `stage` outputs the current encoding.
- Enter press in each state:
  - A_LO: `op_a[3:0]` ← synchronised nibble, go to A_HI.
  - A_HI: `op_a[7:4]` ← synchronised nibble, go to B_LO.
  - B_LO: `op_b[3:0]` ← synchronised nibble, go to B_HI.
  - B_HI: `op_b[7:4]` ← synchronised nibble, go to OP.
  - OP: `opcode` ← synchronised [5:4], go to ISSUE.
  - ISSUE: press is ignored.
- In ISSUE, `cmd_valid`=1. When `cmd_valid` and `cmd_ready` are both high on an edge, the command transfers and the FSM goes to A_LO.
- While in ISSUE, `op_a`, `op_b` and `opcode` are held stable.
- Operands keep their values after issue until they are overwritten.
- A clear press from any state:
  - zeroes `op_a`, `op_b` and `opcode`;
  - drops `cmd_valid`;
  - goes to A_LO.
- Clear overrides an enter press in the same cycle, and also overrides an in-flight handshake: if `cmd_ready` is high in that cycle, no transfer occurs.
- Opcode values (package enum): ADD=0, SUB=1, AND=2, OR=3.

## Timing
- Reset values:
  - `cmd_valid`=0, `op_a`=0, `op_b`=0, `opcode`=0, `stage`=0 (A_LO).
  - Synchroniser flops, debounced levels and debounce counters all at 0.
- Latency, counted from the first edge that samples a raw enter high that then stays stable:
  - The press pulse occurs on edge 2+`DEBOUNCE_CYCLES`.
  - The captured field and the new `stage` are visible after edge 3+`DEBOUNCE_CYCLES`.
- `cmd_valid` rises on the same edge that loads `opcode`.
- `cmd_valid` falls on the edge following the transfer (or following a clear).
- `cmd_ready` may be held high continuously: the command transfers on the first cycle of ISSUE, and `cmd_valid` is high for exactly 1 cycle.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronised cycles produce no press.
- A held button produces exactly one press. Release must then debounce before another press can occur.
- Reset asserted mid-entry or mid-handshake returns every output to its reset value on that edge.

## Structure
- Shared `calc_pkg` holds:
  - the state enum, with the encodings above;
  - the opcode enum;
  - the operand width constant (8).
- Sub-module `calc_debounce` (synchroniser + debounce counter + rising-edge pulse) is instantiated twice, for enter and clear.
  - The data-bit synchronisers stay in the top-level sequencer.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES`=4.
- Reset: hold `rst_n`=0 for 3 cycles → all outputs 0 and `stage`=0; raw enter held high during reset produces no press afterward.
- Full entry: enter presses with nibbles 5, 0, A, 0, then opcode 1, with `cmd_ready`=1 → `cmd_valid` high for 1 cycle with `op_a`=0x05, `op_b`=0x0A, `opcode`=1; `stage` then returns to 0.
- Backpressure: complete an entry with `cmd_ready`=0 for 10 cycles and issue an extra enter press during that window → `cmd_valid` stays high, fields are unchanged and `stage`=5; then `cmd_ready`=1 for 1 cycle → transfer, and `stage`=0 on the next cycle.
- Bounce: enter toggling high/low every 2 cycles for 20 cycles, then held stable high → exactly one press, with A_LO→A_HI after the stable window.
- Clear:
  - press clear in B_HI → `op_a`=`op_b`=0 and `stage`=0;
  - assert clear and `cmd_ready` in the same ISSUE cycle → no transfer, `cmd_valid` drops.
- Enable gating: `ena`=0 during a full press sequence → `stage` is unchanged; `ena`=1 → the next press advances normally.

Source files
------------

// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared types and constants for the calculator entry path.
//   state_e   : entry sequencer states; the encodings drive the status LEDs
//   opcode_e  : operation selector handed to the calculator core
//   OPERAND_W : operand width in bits
//   NIBBLE_W  : width of one switch-entered operand slice
// -----------------------------------------------------------------------------
package calc_pkg;

  localparam int unsigned OPERAND_W = 8;
  localparam int unsigned NIBBLE_W  = 4;

  typedef enum logic [2:0] {
    ST_A_LO  = 3'd0,
    ST_A_HI  = 3'd1,
    ST_B_LO  = 3'd2,
    ST_B_HI  = 3'd3,
    ST_OP    = 3'd4,
    ST_ISSUE = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    OPC_ADD = 2'd0,
    OPC_SUB = 2'd1,
    OPC_AND = 2'd2,
    OPC_OR  = 2'd3
  } opcode_e;

endpackage

// File: rtl/calc_debounce.sv
// -----------------------------------------------------------------------------
// calc_debounce
// Two-flop synchroniser, debounce counter and rising-edge press pulse for one
// push button.
//   clk     : system clock
//   rst_n   : synchronous active-low reset
//   btn_i   : raw asynchronous button level
//   press_o : one-cycle pulse on the accepted (debounced) rising edge
// The debounced level only flips after the synchronised level has disagreed
// with it for DEBOUNCE_CYCLES consecutive cycles (DEBOUNCE_CYCLES >= 2).
// -----------------------------------------------------------------------------
module calc_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  // The counter only needs to reach DEBOUNCE_CYCLES-1: the flip happens on the
  // edge that would have taken it to DEBOUNCE_CYCLES.
  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q;
        press_d = sync_q;         // pulse only on the accepted rising edge
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: flops are written with non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      meta_q  <= btn_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/calc_entry_sequencer.sv
// -----------------------------------------------------------------------------
// calc_entry_sequencer
// Turns switch/button activity into one complete calculator command and offers
// it to the core over a valid/ready handshake.
//   clk       : system clock
//   rst_n     : synchronous active-low reset
//   ena       : design enable; button presses are ignored while low
//   ui_in     : raw inputs, [3:0] nibble, [5:4] opcode, [6] clear, [7] enter
//   cmd_valid : command available (high in ISSUE)
//   cmd_ready : core accepts the command
//   op_a      : operand A
//   op_b      : operand B
//   opcode    : operation selector
//   stage     : current state encoding, for status LEDs
// -----------------------------------------------------------------------------
module calc_entry_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [7:0]           ui_in,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [OPERAND_W-1:0] op_a,
  output logic [OPERAND_W-1:0] op_b,
  output logic [1:0]           opcode,
  output logic [2:0]           stage
);

  // ---------------------------------------------------------------------------
  // Input conditioning: data/opcode switches get a plain 2-flop synchroniser;
  // the two buttons are synchronised and debounced inside calc_debounce.
  // ---------------------------------------------------------------------------
  logic [5:0] data_meta_q;
  logic [5:0] data_sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_meta_q <= '0;
      data_sync_q <= '0;
    end else begin
      data_meta_q <= ui_in[5:0];
      data_sync_q <= data_meta_q;
    end
  end

  logic enter_pulse;
  logic clear_pulse;

  calc_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_enter_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (ui_in[7]),
    .press_o (enter_pulse)
  );

  calc_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_clear_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (ui_in[6]),
    .press_o (clear_pulse)
  );

  logic enter_press;
  logic clear_press;

  assign enter_press = enter_pulse & ena;
  assign clear_press = clear_pulse & ena;

  logic [NIBBLE_W-1:0] nibble;
  assign nibble = data_sync_q[NIBBLE_W-1:0];

  // ---------------------------------------------------------------------------
  // State and command registers
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [OPERAND_W-1:0] op_a_q, op_a_d;
  logic [OPERAND_W-1:0] op_b_q, op_b_d;
  opcode_e              opcode_q, opcode_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_A_LO;
      op_a_q   <= '0;
      op_b_q   <= '0;
      opcode_q <= OPC_ADD;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      opcode_q <= opcode_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state. Clear wins over both an enter press and a pending handshake.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (clear_press) begin
      state_d = ST_A_LO;
    end else begin
      unique case (state_q)
        ST_A_LO:  if (enter_press) state_d = ST_A_HI;
        ST_A_HI:  if (enter_press) state_d = ST_B_LO;
        ST_B_LO:  if (enter_press) state_d = ST_B_HI;
        ST_B_HI:  if (enter_press) state_d = ST_OP;
        ST_OP:    if (enter_press) state_d = ST_ISSUE;
        ST_ISSUE: if (cmd_valid && cmd_ready) state_d = ST_A_LO;
        default:  state_d = ST_A_LO;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Field capture. Nothing is captured in ISSUE, which keeps the offered
  // command stable until it transfers; after transfer the fields simply stay
  // until the next entry overwrites them.
  // ---------------------------------------------------------------------------
  always_comb begin
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    opcode_d = opcode_q;
    if (clear_press) begin
      op_a_d   = '0;
      op_b_d   = '0;
      opcode_d = OPC_ADD;
    end else if (enter_press) begin
      unique case (state_q)
        ST_A_LO:  op_a_d[3:0] = nibble;
        ST_A_HI:  op_a_d[7:4] = nibble;
        ST_B_LO:  op_b_d[3:0] = nibble;
        ST_B_HI:  op_b_d[7:4] = nibble;
        ST_OP:    opcode_d    = opcode_e'(data_sync_q[5:4]);
        default:  ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. A clear press masks cmd_valid in its own cycle so the core can
  // never see a valid/ready transfer of a command that is being discarded.
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_valid = (state_q == ST_ISSUE) && !clear_press;
    stage     = state_q;
    op_a      = op_a_q;
    op_b      = op_b_q;
    opcode    = opcode_q;
  end

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// -----------------------------------------------------------------------------
// tb_calc_entry_sequencer
// Scoreboard bench: stimulus updates a command-level model and queues every
// command expected to reach the core; an independent monitor pops and checks
// on each valid/ready transfer.
// -----------------------------------------------------------------------------
module tb_calc_entry_sequencer;

  localparam int unsigned D = 4;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [1:0] opcode;
  logic [2:0] stage;

  int checks = 0;
  int errors = 0;

  // Command-level model: fields entered so far and how many entry steps are
  // done (0..4 entering, 5 = command waiting for the core).
  logic [7:0] m_a, m_b;
  logic [1:0] m_op;
  int         m_step;
  cmd_t       exp_q[$];

  always #5 clk = ~clk;

  calc_entry_sequencer #(
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .ui_in     (ui_in),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .opcode    (opcode),
    .stage     (stage)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples mid-cycle, so valid/ready seen here are the values the
  // next rising edge will act on.
  initial begin
    cmd_t c;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_transfer: a=0x%0h b=0x%0h op=%0d with no command expected", op_a, op_b, opcode);
        end else begin
          c = exp_q.pop_front();
          check("xfer_op_a", op_a, c.a);
          check("xfer_op_b", op_b, c.b);
          check("xfer_opcode", opcode, c.op);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check_fields(input string tag);
    check({tag, "_op_a"}, op_a, m_a);
    check({tag, "_op_b"}, op_b, m_b);
    check({tag, "_opcode"}, opcode, m_op);
  endtask

  task automatic model_reset();
    m_a = 8'h00; m_b = 8'h00; m_op = 2'd0; m_step = 0;
  endtask

  // Hold enter with the given switches, check exact press latency, the single
  // advance while held, then release and let the release debounce.
  task automatic press_enter(input logic [3:0] nib, input logic [1:0] opc);
    int   old_step, new_step;
    cmd_t c;
    old_step = m_step;
    new_step = m_step;
    if (ena && m_step < 5) begin
      case (m_step)
        0: m_a = (m_a & 8'hF0) | 8'(nib);
        1: m_a = (m_a & 8'h0F) | (8'(nib) << 4);
        2: m_b = (m_b & 8'hF0) | 8'(nib);
        3: m_b = (m_b & 8'h0F) | (8'(nib) << 4);
        default: begin
          m_op = opc;
          c.a = m_a; c.b = m_b; c.op = m_op;
          exp_q.push_back(c);
        end
      endcase
      new_step = m_step + 1;
    end
    @(posedge clk); #2;
    ui_in = {1'b1, 1'b0, opc, nib};
    repeat (2 + D) @(posedge clk);
    @(negedge clk);
    check("stage_before_capture", stage, old_step);
    @(negedge clk);
    check("stage_after_capture", stage, new_step);
    check("valid_after_capture", cmd_valid, new_step == 5);
    check_fields("capture");
    if (new_step == 5 && cmd_ready) begin
      @(negedge clk);
      check("stage_after_xfer", stage, 0);
      check("valid_one_cycle", cmd_valid, 0);
      new_step = 0;
    end
    repeat (D + 4) @(negedge clk);
    check("stage_while_held", stage, new_step);
    @(posedge clk); #2;
    ui_in[7] = 1'b0;
    repeat (D + 6) @(posedge clk);
    m_step = new_step;
  endtask

  // Clear press; optionally raise cmd_ready exactly in the cycle the clear
  // press is active, which must not produce a transfer.
  task automatic press_clear(input bit with_ready);
    @(posedge clk); #2;
    ui_in[6] = 1'b1;
    repeat (2 + D) @(posedge clk);
    if (with_ready) begin
      #2 cmd_ready = 1'b1;
    end
    @(negedge clk);
    check("stage_before_clear", stage, m_step);
    @(posedge clk); #2;
    cmd_ready = 1'b0;
    if (m_step == 5 && exp_q.size() > 0) void'(exp_q.pop_back());
    model_reset();
    @(negedge clk);
    check("stage_after_clear", stage, 0);
    check("valid_after_clear", cmd_valid, 0);
    check_fields("clear");
    @(posedge clk); #2;
    ui_in[6] = 1'b0;
    repeat (D + 6) @(posedge clk);
  endtask

  task automatic give_ready();
    @(posedge clk); #2;
    cmd_ready = 1'b1;
    @(posedge clk); #2;
    cmd_ready = 1'b0;
    m_step = 0;
    @(negedge clk);
    check("stage_after_ready", stage, 0);
    check("valid_after_ready", cmd_valid, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    ena       = 1'b1;
    cmd_ready = 1'b0;
    ui_in     = 8'h80;   // enter held during reset
    model_reset();

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_stage", stage, 0);
    check("reset_valid", cmd_valid, 0);
    check_fields("reset");
    @(posedge clk); #2;
    rst_n = 1'b1;
    ui_in = 8'h00;
    repeat (2 * D + 10) @(posedge clk);
    @(negedge clk);
    check("no_press_after_reset", stage, 0);

    // Full entry with the core always ready
    cmd_ready = 1'b1;
    press_enter(4'h5, 2'd0);
    press_enter(4'h0, 2'd0);
    press_enter(4'hA, 2'd0);
    press_enter(4'h0, 2'd0);
    press_enter(4'h0, 2'd1);
    cmd_ready = 1'b0;

    // Backpressure with an ignored extra press while waiting
    press_enter(4'h3, 2'd0);
    press_enter(4'hC, 2'd0);
    press_enter(4'h7, 2'd0);
    press_enter(4'hE, 2'd0);
    press_enter(4'h0, 2'd2);
    repeat (10) @(negedge clk);
    check("bp_stage", stage, 5);
    check("bp_valid", cmd_valid, 1);
    press_enter(4'h9, 2'd3);
    check_fields("bp_after_extra");
    give_ready();

    // Bounce: 2-cycle toggles must not press, then a stable press advances once
    ui_in[3:0] = 4'h9;
    repeat (10) begin
      @(posedge clk); #2;
      ui_in[7] = ~ui_in[7];
      @(posedge clk);
    end
    repeat (D + 4) @(negedge clk);
    check("bounce_no_press", stage, m_step);
    press_enter(4'h9, 2'd0);

    // Clear in B_HI
    press_enter(4'h6, 2'd0);
    press_enter(4'hB, 2'd0);
    press_clear(1'b0);

    // Clear colliding with cmd_ready in ISSUE
    press_enter(4'h1, 2'd0);
    press_enter(4'h2, 2'd0);
    press_enter(4'h3, 2'd0);
    press_enter(4'h4, 2'd0);
    press_enter(4'h0, 2'd3);
    press_clear(1'b1);

    // Enable gating
    ena = 1'b0;
    press_enter(4'hF, 2'd0);
    ena = 1'b1;
    press_enter(4'hD, 2'd0);

    // Reset mid-entry
    press_enter(4'h8, 2'd0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midreset_stage", stage, 0);
    check("midreset_valid", cmd_valid, 0);
    model_reset();
    check_fields("midreset");
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Randomised commands with random core readiness
    for (int k = 0; k < 4; k++) begin
      cmd_ready = 1'($urandom_range(0, 1));
      for (int s = 0; s < 5; s++) begin
        press_enter(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      end
      if (!cmd_ready) begin
        repeat ($urandom_range(1, 6)) @(posedge clk);
        give_ready();
      end
      cmd_ready = 1'b0;
    end

    repeat (4) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
